// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: size codes, FSM states and
// the word-index width helper.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  function automatic int idx_width(input int depth_words);
    return $clog2(depth_words);
  endfunction

  localparam int DEF_DEPTH_WORDS = 256;
  localparam int DEF_IDX_W       = idx_width(DEF_DEPTH_WORDS);

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte enables and replicated data, misalign detection,
// and load lane extraction with sign/zero extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] raw,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic        misalign,
  output logic [31:0] rdata
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = raw[7:0];
    case (addr_lo)
      2'd0:    byte_sel = raw[7:0];
      2'd1:    byte_sel = raw[15:8];
      2'd2:    byte_sel = raw[23:16];
      default: byte_sel = raw[31:24];
    endcase
    half_sel = addr_lo[1] ? raw[31:16] : raw[15:0];
  end

  always_comb begin
    be        = 4'b0000;
    wdata_rep = wdata;
    misalign  = 1'b0;
    rdata     = 32'h0;
    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata     = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        misalign  = addr_lo[0];
        wdata_rep = {2{wdata[15:0]}};
        if (!addr_lo[0]) begin
          be    = addr_lo[1] ? 4'b1100 : 4'b0011;
          rdata = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
        end
      end
      SZ_WORD: begin
        misalign = (addr_lo != 2'b00);
        if (addr_lo == 2'b00) begin
          be    = 4'b1111;
          rdata = raw;
        end
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed response latency.
// state  | meaning
// S_IDLE | ready for a request; capture on req_valid
// S_WAIT | latency countdown, busy
// S_RESP | access performed; response registered on leaving
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         IDX_W    = idx_width(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t             state;
  logic [3:0]         cnt;
  logic               cap_we;
  logic [1:0]         cap_size;
  logic               cap_unsigned;
  logic [IDX_W+1:0]   cap_addr;
  logic [31:0]        cap_wdata;
  logic [31:0]        mem [DEPTH_WORDS];

  logic               accept;
  logic               enter_resp;
  logic               use_req;
  logic               a_we;
  logic [1:0]         a_size;
  logic               a_unsigned;
  logic [IDX_W+1:0]   a_addr;
  logic [31:0]        a_wdata;
  logic [IDX_W-1:0]   a_idx;
  logic [31:0]        raw;
  logic [3:0]         be;
  logic [31:0]        wdata_rep;
  logic               misalign;
  logic [31:0]        ld_data;
  logic               mem_write;
  logic               unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:IDX_W+2];

  assign accept     = (state == S_IDLE) && req_valid;
  assign enter_resp = (accept && (LATENCY == 1)) || ((state == S_WAIT) && (cnt == 4'd1));

  // With LATENCY=1 the write commits on the accept edge, before capture completes.
  assign use_req    = (state == S_IDLE);
  assign a_we       = use_req ? req_we                  : cap_we;
  assign a_size     = use_req ? req_size                : cap_size;
  assign a_unsigned = use_req ? req_unsigned            : cap_unsigned;
  assign a_addr     = use_req ? req_addr[IDX_W+1:0]     : cap_addr;
  assign a_wdata    = use_req ? req_wdata               : cap_wdata;
  assign a_idx      = a_addr[IDX_W+1:2];
  assign raw        = mem[a_idx];

  dmem_lane_align u_align (
    .size        (a_size),
    .addr_lo     (a_addr[1:0]),
    .is_unsigned (a_unsigned),
    .wdata       (a_wdata),
    .raw         (raw),
    .be          (be),
    .wdata_rep   (wdata_rep),
    .misalign    (misalign),
    .rdata       (ld_data)
  );

  assign mem_write = rst && enter_resp && a_we && !misalign;

  // Storage has no reset so its contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_write) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[a_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      cnt          <= 4'd0;
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 32'h0;
      rsp_err      <= 1'b0;
      cap_we       <= 1'b0;
      cap_size     <= SZ_BYTE;
      cap_unsigned <= 1'b0;
      cap_addr     <= '0;
      cap_wdata    <= 32'h0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            cap_we       <= req_we;
            cap_size     <= req_size;
            cap_unsigned <= req_unsigned;
            cap_addr     <= req_addr[IDX_W+1:0];
            cap_wdata    <= req_wdata;
            cnt          <= CNT_INIT;
            req_ready    <= 1'b0;
            state        <= (LATENCY == 1) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= S_RESP;
        end
        S_RESP: begin
          rsp_valid <= 1'b1;
          rsp_err   <= misalign;
          rsp_rdata <= (cap_we || misalign) ? 32'h0 : ld_data;
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a reference word memory predicts each
// response, which is checked against rsp_* along with its latency.
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          t_acc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl [DEPTH];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata);
    exp_t        e;
    int          idx;
    int          lo;
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    idx     = int'(addr[9:2]);
    lo      = int'(addr[1:0]);
    w       = mdl[idx];
    e.rdata = 32'h0;
    e.err   = (size == 2'b11) || (size == 2'b01 && lo[0]) || (size == 2'b10 && lo != 0);
    e.t_acc = 0;
    if (!e.err) begin
      if (we) begin
        case (size)
          2'b00:   w[8*lo +: 8] = wdata[7:0];
          2'b01:   w[8*lo +: 16] = wdata[15:0];
          default: w = wdata;
        endcase
        mdl[idx] = w;
      end else begin
        b = w[8*lo +: 8];
        h = w[8*lo +: 16];
        case (size)
          2'b00:   e.rdata = uns ? {24'h0, b} : {{24{b[7]}}, b};
          2'b01:   e.rdata = uns ? {16'h0, h} : {{16{h[15]}}, h};
          default: e.rdata = w;
        endcase
      end
    end
    return e;
  endfunction

  always @(posedge clk) begin
    #1;
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_rsp", 32'(rsp_valid), 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        chk("latency", 32'(cyc - e.t_acc), 32'(LAT));
      end
    end
  end

  task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
  endtask

  task automatic scramble();
    req_we       = 1'($urandom);
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_addr     = $urandom;
    req_wdata    = $urandom;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("ready_timeout", 32'(req_ready), 32'h1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      if (sb.size() != 0) chk("ready_busy", 32'(req_ready), 32'h0);
      n++;
    end
    if (sb.size() != 0) begin
      chk("rsp_timeout", 32'(sb.size()), 32'h0);
      sb.delete();
    end
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    @(negedge clk);
    drive(we, size, uns, addr, wdata);
    wait_ready();
    @(posedge clk);
    #1;
    e       = model(we, size, uns, addr, wdata);
    e.t_acc = cyc;
    sb.push_back(e);
    req_valid = 1'b0;
    scramble();
    drain();
  endtask

  task automatic reset_hold(input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 2'b10, 1'b0, addr, wdata);
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'h1);
    chk("rst_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_err", 32'(rsp_err), 32'h0);
    req_valid = 1'b0;
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   t0;
    int   n;
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
    rst = 1'b0;
    req_valid = 1'b0;
    scramble();

    reset_hold(32'h30, 32'h1111_1111);
    issue(1'b1, 2'b10, 1'b0, 32'h30, 32'hCAFE_F00D);
    reset_hold(32'h30, 32'h5555_5555);
    issue(1'b0, 2'b10, 1'b0, 32'h30, 32'h0);

    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    issue(1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_0080);
    issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    issue(1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
    issue(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
    issue(1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF_1234);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);

    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'hA5A5_A5A5);
    issue(1'b1, 2'b01, 1'b0, 32'h21, 32'h0000_7777);
    issue(1'b1, 2'b10, 1'b0, 32'h22, 32'h0BAD_0BAD);
    issue(1'b0, 2'b11, 1'b0, 32'h20, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);

    issue(1'b1, 2'b10, 1'b0, DEPTH * 4 + 4, 32'h0BAD_C0DE);
    issue(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);

    // Held request while busy: taken only after return to IDLE.
    @(negedge clk);
    drive(1'b1, 2'b10, 1'b0, 32'h8, 32'h1357_2468);
    wait_ready();
    @(posedge clk);
    #1;
    e       = model(1'b1, 2'b10, 1'b0, 32'h8, 32'h1357_2468);
    e.t_acc = cyc;
    t0      = cyc;
    sb.push_back(e);
    drive(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      chk("hs_valid_busy", 32'(rsp_valid), 32'h0);
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    chk("issue_interval", 32'(cyc - t0), 32'(LAT + 1));
    e       = model(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
    e.t_acc = cyc;
    sb.push_back(e);
    req_valid = 1'b0;
    scramble();
    drain();

    // Reset during WAIT of a store aborts it.
    @(negedge clk);
    drive(1'b1, 2'b10, 1'b0, 32'h4, 32'hFFFF_0000);
    wait_ready();
    @(posedge clk);
    #2;
    rst = 1'b0;
    req_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("midrst_valid", 32'(rsp_valid), 32'h0);
      chk("midrst_ready", 32'(req_ready), 32'h1);
    end
    rst = 1'b1;
    repeat (4) @(negedge clk);
    issue(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
    issue(1'b0, 2'b00, 1'b1, 32'h7, 32'h0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
